// File: rtl/sm_regdump_if.sv
// sm_regdump_if: bundle of the dump engine's register-access and byte-stream signals.
//   start    : dump request pulse (host -> engine)
//   regAddr  : debug register index driven to the CPU (engine -> CPU)
//   regData  : debug register value returned by the CPU, combinational on regAddr
//   tx_data  : stream byte (engine -> sink)
//   tx_valid : tx_data valid (engine -> sink)
//   tx_ready : sink accepts the byte on valid & ready at a rising edge (sink -> engine)
//   busy     : engine is not idle
//   done     : one-cycle pulse once the final byte has been accepted
// The master modport is the engine side; slave is the host/CPU/sink side.
interface sm_regdump_if;
    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, regData, tx_ready,
        output regAddr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, regData, tx_ready,
        input  regAddr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/sm_regdump.sv
// sm_regdump: debug-port register dumper.
// On a start pulse it walks register indices 0..NUM_REGS-1 over the CPU debug port and emits
// each as a 5-byte record {index, data[31:24], data[23:16], data[15:8], data[7:0]} on a
// valid/ready byte stream. Index 0 reads back the PC on the CPU side.
// Ports:
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : sm_regdump_if.master (start, regAddr, regData, tx_*, busy, done)
// Parameters:
//   NUM_REGS : number of indices dumped, legal range 1..32
module sm_regdump #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    sm_regdump_if.master      bus
);

    localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StSend,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] snap_q, snap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 5'd0;
            byte_cnt_q <= 3'd0;
            snap_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            snap_q     <= snap_d;
        end
    end

    // Outputs decode straight from state so reset drops tx_valid/busy without a clock edge.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        byte_cnt_d   = byte_cnt_q;
        snap_d       = snap_q;
        bus.regAddr  = 5'd0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    idx_d   = 5'd0;
                    state_d = StCapture;
                end
            end

            StCapture: begin
                // One cycle with regAddr settled, then freeze the value for the whole record.
                bus.regAddr = idx_q;
                snap_d      = bus.regData;
                byte_cnt_d  = 3'd0;
                state_d     = StSend;
            end

            StSend: begin
                bus.regAddr  = idx_q;
                bus.tx_valid = 1'b1;
                case (byte_cnt_q)
                    3'd0:    bus.tx_data = {3'b000, idx_q};
                    3'd1:    bus.tx_data = snap_q[31:24];
                    3'd2:    bus.tx_data = snap_q[23:16];
                    3'd3:    bus.tx_data = snap_q[15:8];
                    3'd4:    bus.tx_data = snap_q[7:0];
                    default: bus.tx_data = 8'h00;
                endcase
                if (bus.tx_ready) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd4) begin
                        // The last index ends the dump, so idx never needs to wrap.
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = StCapture;
                        end
                    end
                end
            end

            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/sm_regdump.md
Name: sm_regdump

Overview:
- Debug-port reader for the CPU's register-access interface. It drives regAddr and samples regData.
- On a start pulse it walks register indices 0..NUM_REGS-1 and serialises each as a 5-byte record onto a valid/ready byte stream. The stream feeds a UART transmitter or a host link.
- Index 0 returns the PC on the CPU side, so record 0 carries the PC.
- Sits beside the CPU at top level; needs no CPU changes.

Parameters:
- NUM_REGS, 32, number of register indices dumped, starting at 0; legal range 1..32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  dump request; one-cycle pulse, sampled only in IDLE
- regAddr  out  5  debug register address to CPU
- regData  in  32  debug register data from CPU; combinational w.r.t. regAddr
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts the byte when tx_valid & tx_ready at a rising edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Interface: clk is the single clock; rst is an asynchronous, active-high reset.
- Reset (asynchronous, immediate):
  - state=IDLE, idx=0, byte counter=0, shift register=0
  - regAddr=0, tx_valid=0, tx_data=0, busy=0, done=0
- States: IDLE, CAPTURE, SEND, DONE.
- IDLE:
  - regAddr=0, tx_valid=0.
  - start=1 -> idx=0, go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - regAddr=idx.
  - At the edge, latch regData into a 32-bit snapshot and set byte counter=0.
  - Go to SEND.
- SEND:
  - regAddr held at idx; tx_valid=1.
  - Byte order: byte0={3'b000, idx[4:0]}, byte1=snap[31:24], byte2=snap[23:16], byte3=snap[15:8], byte4=snap[7:0].
  - tx_data must stay stable while tx_valid=1 and tx_ready=0; no timeout.
  - On accept: byte counter +1.
  - On accept of byte4:
    - If idx==NUM_REGS-1, go to DONE.
    - Otherwise idx+1, go to CAPTURE.
  - tx_valid drops only in CAPTURE or DONE, never mid-record.
- DONE (1 cycle): done=1, tx_valid=0, then go to IDLE.
- Latency with tx_ready tied high:
  - Each record takes 6 cycles: 1 CAPTURE + 5 SEND.
  - With start sampled at edge 0: first tx_valid cycle begins at edge 1; done is high for the cycle after edge 6*NUM_REGS.
- Boundary conditions:
  - start outside IDLE (including the DONE cycle) is ignored; no queuing.
  - start held high across several cycles in IDLE triggers one dump. A re-trigger needs start high in IDLE after DONE.
  - tx_ready while tx_valid=0 is ignored.
  - NUM_REGS=1: a single record for the PC, then DONE.
  - idx is 5 bits; with NUM_REGS=32 it never wraps because the last index ends the dump.
  - Each record is snapshotted independently; the CPU keeps running, so records are not mutually atomic.
  - rst mid-dump: tx_valid falls asynchronously, any partial record is abandoned, done is not pulsed, state returns to IDLE.

Test Plan:
- Preload r1=0x12345678, r31=0xDEADBEEF; NUM_REGS=32; tx_ready=1; pulse start -> 160 bytes.
  - Record 1 = 01 12 34 56 78; record 31 = 1F DE AD BE EF; record 0 begins with 00 followed by the PC.
  - done pulses once, 192 cycles after start is sampled; busy low the following cycle.
- Random backpressure on tx_ready (~50% duty) -> byte sequence identical to the tx_ready=1 run; tx_data never changes while tx_valid=1 and tx_ready=0.
- start pulsed again at byte 40 of a dump -> ignored; exactly 160 bytes and one done pulse.
- rst asserted while byte2 of record 5 is pending -> tx_valid=0 and busy=0 without waiting for a clock edge, no done pulse; a new start produces a full dump from record 0.
- NUM_REGS=1, PC=0x00000010 -> bytes 00 00 00 00 10, then done.
- tx_ready held 0 for 1000 cycles in the first SEND -> tx_valid=1 and tx_data=0x00 held throughout; the dump resumes normally when tx_ready is released.
